// File: rtl/beam_scan_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : beam_scan_scheduler_if
//  Brief    : Control, LUT and beamformer signal bundle of beam_scan_scheduler.
//             master = scheduler side, slave = surrounding control/LUT/beamformer.
//  Revision : 1.0 - initial release
// ============================================================================
interface beam_scan_scheduler_if #(
  parameter int ANGLE_WIDTH = 4,
  parameter int SIN_WIDTH   = 17
);
  // Top-level control
  logic                   start_in;
  logic                   stop_in;
  logic                   continuous_in;
  // Sine/sign lookup table
  logic [ANGLE_WIDTH-1:0] angle_addr_out;
  logic [SIN_WIDTH-1:0]   sin_in;
  logic                   sign_in;
  // Beamformer / receive chain
  logic [SIN_WIDTH-1:0]   sin_value_out;
  logic                   sign_bit_out;
  logic                   burst_en_out;
  logic                   listen_out;
  logic                   frame_start_out;
  logic                   sweep_done_out;
  logic                   busy_out;

  modport master (
    input  start_in, stop_in, continuous_in, sin_in, sign_in,
    output angle_addr_out, sin_value_out, sign_bit_out, burst_en_out,
           listen_out, frame_start_out, sweep_done_out, busy_out
  );

  modport slave (
    output start_in, stop_in, continuous_in, sin_in, sign_in,
    input  angle_addr_out, sin_value_out, sign_bit_out, burst_en_out,
           listen_out, frame_start_out, sweep_done_out, busy_out
  );
endinterface
`default_nettype wire

// File: rtl/beam_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : beam_scan_scheduler
//  Brief    : Steps the transmit beamformer through an angular sweep. Each
//             frame fetches the sine/sign pair, gates the burst, then opens
//             the listen window until the frame period expires.
//  Revision : 1.0 - initial release
// ============================================================================
module beam_scan_scheduler #(
  parameter int PERIOD_DURATION = 16777216,
  parameter int BURST_DURATION  = 524288,
  parameter int NUM_ANGLES      = 16,
  parameter int ANGLE_WIDTH     = 4,
  parameter int LUT_LATENCY     = 2,
  parameter int SIN_WIDTH       = 17,
  parameter int CNT_WIDTH       = 25
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  beam_scan_scheduler_if.master bus
);

  // Reject configurations where the frame cannot hold setup + burst + listen
  if ((PERIOD_DURATION <= LUT_LATENCY + BURST_DURATION) || (NUM_ANGLES < 2) ||
      (LUT_LATENCY < 1) || ((longint'(1) << CNT_WIDTH) < longint'(PERIOD_DURATION)) ||
      ((longint'(1) << ANGLE_WIDTH) < longint'(NUM_ANGLES))) begin : g_cfg_error
    $error("beam_scan_scheduler: illegal parameter configuration");
  end

  localparam logic [CNT_WIDTH-1:0]   c_setup_last  = CNT_WIDTH'(LUT_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0]   c_burst_last  = CNT_WIDTH'(LUT_LATENCY + BURST_DURATION - 1);
  localparam logic [CNT_WIDTH-1:0]   c_period_last = CNT_WIDTH'(PERIOD_DURATION - 1);
  localparam logic [ANGLE_WIDTH-1:0] c_last_angle  = ANGLE_WIDTH'(NUM_ANGLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_BURST  = 2'd2,
    ST_LISTEN = 2'd3
  } state_t;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_frame_cnt;
  logic [ANGLE_WIDTH-1:0] r_angle;
  logic                   r_stop_pending;
  logic [SIN_WIDTH-1:0]   r_sin_value;
  logic                   r_sign_bit;
  logic                   r_burst_en;
  logic                   r_listen;
  logic                   r_frame_start;
  logic                   r_sweep_done;
  logic                   r_busy;

  logic [CNT_WIDTH-1:0]   w_cnt_inc;
  logic [ANGLE_WIDTH-1:0] w_next_angle;
  logic                   w_last_angle;
  logic                   w_sweep_arm;
  logic                   w_end_sweep;

  assign w_cnt_inc    = r_frame_cnt + CNT_WIDTH'(1);
  assign w_last_angle = (r_angle == c_last_angle);
  assign w_next_angle = w_last_angle ? '0 : r_angle + ANGLE_WIDTH'(1);
  // Raise sweep_done so it is high exactly on the final cycle of the last angle
  assign w_sweep_arm  = (w_cnt_inc == c_period_last) && w_last_angle;
  // A stop arriving on the final LISTEN cycle still counts at this boundary
  assign w_end_sweep  = r_stop_pending || bus.stop_in ||
                        (w_last_angle && !bus.continuous_in);

  // Frame sequencer: state, counters and all registered outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state        <= ST_IDLE;
      r_frame_cnt    <= '0;
      r_angle        <= '0;
      r_stop_pending <= 1'b0;
      r_sin_value    <= '0;
      r_sign_bit     <= 1'b0;
      r_burst_en     <= 1'b0;
      r_listen       <= 1'b0;
      r_frame_start  <= 1'b0;
      r_sweep_done   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_sweep_done  <= 1'b0;
      if ((r_state != ST_IDLE) && bus.stop_in) begin
        r_stop_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.start_in) begin
            r_state        <= ST_SETUP;
            r_frame_cnt    <= '0;
            r_angle        <= '0;
            r_stop_pending <= 1'b0;
            r_frame_start  <= 1'b1;
            r_busy         <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_frame_cnt  <= w_cnt_inc;
          r_sweep_done <= w_sweep_arm;
          if (r_frame_cnt == c_setup_last) begin
            r_sin_value <= bus.sin_in;
            r_sign_bit  <= bus.sign_in;
            r_burst_en  <= 1'b1;
            r_state     <= ST_BURST;
          end
        end
        ST_BURST: begin
          r_frame_cnt  <= w_cnt_inc;
          r_sweep_done <= w_sweep_arm;
          if (r_frame_cnt == c_burst_last) begin
            r_burst_en <= 1'b0;
            r_listen   <= 1'b1;
            r_state    <= ST_LISTEN;
          end
        end
        ST_LISTEN: begin
          if (r_frame_cnt == c_period_last) begin
            r_frame_cnt <= '0;
            r_listen    <= 1'b0;
            if (w_end_sweep) begin
              r_state        <= ST_IDLE;
              r_angle        <= '0;
              r_stop_pending <= 1'b0;
              r_busy         <= 1'b0;
            end else begin
              r_state       <= ST_SETUP;
              r_angle       <= w_next_angle;
              r_frame_start <= 1'b1;
            end
          end else begin
            r_frame_cnt  <= w_cnt_inc;
            r_sweep_done <= w_sweep_arm;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.angle_addr_out  = r_angle;
  assign bus.sin_value_out   = r_sin_value;
  assign bus.sign_bit_out    = r_sign_bit;
  assign bus.burst_en_out    = r_burst_en;
  assign bus.listen_out      = r_listen;
  assign bus.frame_start_out = r_frame_start;
  assign bus.sweep_done_out  = r_sweep_done;
  assign bus.busy_out        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_beam_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_beam_scan_scheduler
//  Brief    : Self-checking bench for beam_scan_scheduler with a frame-level
//             reference model and a 2-cycle sine/sign LUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_beam_scan_scheduler;
  localparam int PD = 64;
  localparam int BD = 16;
  localparam int NA = 4;
  localparam int LL = 2;
  localparam int AW = 2;
  localparam int SW = 17;
  localparam int CW = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   cur = 0;

  beam_scan_scheduler_if #(.ANGLE_WIDTH(AW), .SIN_WIDTH(SW)) bus ();

  beam_scan_scheduler #(
    .PERIOD_DURATION(PD), .BURST_DURATION(BD), .NUM_ANGLES(NA),
    .ANGLE_WIDTH(AW), .LUT_LATENCY(LL), .SIN_WIDTH(SW), .CNT_WIDTH(CW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus)
  );

  // Clock generation
  always #5 clk = ~clk;

  // LUT: address registered once, data valid by the second cycle after a change
  logic [AW-1:0] lut_q = '0;
  always @(posedge clk) lut_q <= bus.angle_addr_out;
  assign bus.sin_in  = SW'(1000 * (int'(lut_q) + 1));
  assign bus.sign_in = lut_q[0];

  // Frame-level reference model: position inside the frame and the angle index
  bit m_active = 1'b0;
  bit m_sp     = 1'b0;
  bit m_sign   = 1'b0;
  int m_k      = 0;
  int m_angle  = 0;
  int m_sin    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_sp = 1'b0; m_k = 0; m_angle = 0; m_sin = 0; m_sign = 1'b0;
    end else if (!m_active) begin
      if (bus.start_in) begin
        m_active = 1'b1; m_sp = 1'b0; m_k = 0; m_angle = 0;
      end
    end else begin
      if (bus.stop_in) m_sp = 1'b1;
      if (m_k == PD - 1) begin
        if (m_sp || (m_angle == NA - 1 && !bus.continuous_in)) begin
          m_active = 1'b0; m_angle = 0;
        end else begin
          m_angle = (m_angle + 1) % NA;
          m_k     = 0;
        end
      end else begin
        m_k = m_k + 1;
        if (m_k == LL) begin
          m_sin  = 1000 * (m_angle + 1);
          m_sign = (m_angle % 2) == 1;
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",        bus.busy_out,        m_active);
      check("frame_start", bus.frame_start_out, m_active && m_k == 0);
      check("burst_en",    bus.burst_en_out,    m_active && m_k >= LL && m_k < LL + BD);
      check("listen",      bus.listen_out,      m_active && m_k >= LL + BD);
      check("sweep_done",  bus.sweep_done_out,  m_active && m_k == PD - 1 && m_angle == NA - 1);
      check("angle_addr",  bus.angle_addr_out,  m_active ? m_angle : 0);
      check("sin_value",   bus.sin_value_out,   m_sin);
      check("sign_bit",    bus.sign_bit_out,    m_sign);
      check("burst_listen_excl", bus.burst_en_out && bus.listen_out, 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto_cycle(input int c);
    cyc(c - cur);
    cur = c;
  endtask

  task automatic pulse_start;
    bus.start_in = 1'b1;
    cyc(1);
    bus.start_in = 1'b0;
    cur = 0;
  endtask

  task automatic pulse_stop;
    bus.stop_in = 1'b1;
    cyc(1);
    bus.stop_in = 1'b0;
    cur = cur + 1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start_in = 1'b0; bus.stop_in = 1'b0; bus.continuous_in = 1'b0;

    // 1. Reset values, then idle after release
    cyc(3);
    chk_en = 1'b1;
    cyc(2);
    check("rst_sin_value", bus.sin_value_out, 0);
    check("rst_busy", bus.busy_out, 0);
    rst_n = 1'b1;
    cyc(10);
    check("idle_busy", bus.busy_out, 0);

    // 2. Single sweep
    pulse_start();
    check("s2_frame_start_c0", bus.frame_start_out, 1);
    goto_cycle(1);   check("s2_burst_c1", bus.burst_en_out, 0);
    goto_cycle(2);   check("s2_burst_c2", bus.burst_en_out, 1);
                     check("s2_sin_f0", bus.sin_value_out, 1000);
    goto_cycle(17);  check("s2_burst_c17", bus.burst_en_out, 1);
    goto_cycle(18);  check("s2_listen_c18", bus.listen_out, 1);
    goto_cycle(64);  check("s2_hold_c64", bus.sin_value_out, 1000);
    goto_cycle(66);  check("s2_sin_f1", bus.sin_value_out, 2000);
                     check("s2_sign_f1", bus.sign_bit_out, 1);
    goto_cycle(130); check("s2_sin_f2", bus.sin_value_out, 3000);
    goto_cycle(255); check("s2_sweep_done", bus.sweep_done_out, 1);
                     check("s2_sin_f3", bus.sin_value_out, 4000);
    goto_cycle(256); check("s2_idle", bus.busy_out, 0);
                     check("s2_retain_sin", bus.sin_value_out, 4000);
    cyc(3);

    // 3. Continuous sweep, then drop continuous to end after the second sweep
    bus.continuous_in = 1'b1;
    pulse_start();
    goto_cycle(256); check("s3_wrap_start", bus.frame_start_out, 1);
                     check("s3_wrap_angle", bus.angle_addr_out, 0);
    goto_cycle(511); check("s3_sweep_done2", bus.sweep_done_out, 1);
    goto_cycle(600); bus.continuous_in = 1'b0;
    goto_cycle(767); check("s3_sweep_done3", bus.sweep_done_out, 1);
    goto_cycle(768); check("s3_idle", bus.busy_out, 0);
    cyc(3);

    // 4. Stop mid-burst and on the final listen cycle
    pulse_start();
    goto_cycle(70);  pulse_stop();
    goto_cycle(127); check("s4a_busy_c127", bus.busy_out, 1);
    goto_cycle(128); check("s4a_idle_c128", bus.busy_out, 0);
    goto_cycle(150); check("s4a_no_burst", bus.burst_en_out, 0);
    cyc(3);
    pulse_start();
    goto_cycle(127); pulse_stop();
    check("s4b_idle_c128", bus.busy_out, 0);
    cyc(20);

    // 5. Ignored requests: start while busy, stop while idle
    pulse_start();
    goto_cycle(30);  bus.start_in = 1'b1; cyc(1); bus.start_in = 1'b0; cur = 31;
    check("s5_no_restart", bus.listen_out, 1);
    goto_cycle(66);  check("s5_sin_f1", bus.sin_value_out, 2000);
    goto_cycle(256); check("s5_idle", bus.busy_out, 0);
    cyc(2);
    pulse_stop();
    cyc(2);
    pulse_start();
    goto_cycle(255); check("s5_full_sweep", bus.sweep_done_out, 1);
    goto_cycle(256); check("s5_idle2", bus.busy_out, 0);
    cyc(3);

    // 6. Asynchronous reset during burst, then restart
    pulse_start();
    goto_cycle(10);  check("s6_burst_c10", bus.burst_en_out, 1);
    #2 rst_n = 1'b0;
    #1 check("s6_async_burst", bus.burst_en_out, 0);
    check("s6_async_busy", bus.busy_out, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    pulse_start();
    check("s6_restart_angle", bus.angle_addr_out, 0);
    goto_cycle(2);   check("s6_sin_f0", bus.sin_value_out, 1000);
    goto_cycle(66);  check("s6_sin_f1", bus.sin_value_out, 2000);
    goto_cycle(256); check("s6_idle", bus.busy_out, 0);
    cyc(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/beam_scan_scheduler.md
# beam_scan_scheduler

Sequencer that drives `transmit_beamformer` through an angular sweep. For each steering angle it:
- fetches the sine/sign pair from an external lookup table;
- holds `sin_value`/`sign_bit` stable;
- gates the ultrasonic burst for a fixed burst window;
- opens a listen window for the receive path until the frame period expires.

It sits between the top-level control (start/stop, mode switches) and the beamformer/receive chain.

## Interface
- `PERIOD_DURATION`, default 16777216: frame length in clk_in cycles (setup + burst + listen).
- `BURST_DURATION`, default 524288: cycles `burst_en_out` is high per frame.
- `NUM_ANGLES`, default 16: number of steering angles per sweep (≥2).
- `ANGLE_WIDTH`, default 4: width of angle index; 2^ANGLE_WIDTH ≥ NUM_ANGLES.
- `LUT_LATENCY`, default 2: cycles from `angle_addr_out` change to valid `sin_in`/`sign_in` (≥1).
- `SIN_WIDTH`, default 17: sine value width, matches beamformer.
- `CNT_WIDTH`, default 25: frame counter width; 2^CNT_WIDTH ≥ PERIOD_DURATION.

Ports:
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `start_in` in 1: one-cycle start request.
- `stop_in` in 1: one-cycle stop request; takes effect at end of current frame.
- `continuous_in` in 1: 1 = sweep repeats forever; 0 = single sweep. Sampled at each sweep end.
- `angle_addr_out` out ANGLE_WIDTH: LUT address = current angle index.
- `sin_in` in SIN_WIDTH: LUT sine magnitude.
- `sign_in` in 1: LUT sign (1 = steer left).
- `sin_value_out` out SIN_WIDTH: latched sine to beamformer.
- `sign_bit_out` out 1: latched sign to beamformer.
- `burst_en_out` out 1: transmit gate.
- `listen_out` out 1: receive window.
- `frame_start_out` out 1: one-cycle pulse on first SETUP cycle of each frame.
- `sweep_done_out` out 1: one-cycle pulse on last cycle of the frame for angle NUM_ANGLES-1.
- `busy_out` out 1: high in any state except IDLE.

## Operation
- States: IDLE, SETUP, BURST, LISTEN. `frame_cnt` (CNT_WIDTH) counts 0..PERIOD_DURATION-1 within a frame.
- IDLE: outputs low. `start_in` sets angle=0, frame_cnt=0, clears stop_pending, moves to SETUP. `stop_in` is ignored in IDLE.
- SETUP: frame_cnt 0..LUT_LATENCY-1, with `angle_addr_out` = angle. On frame_cnt==LUT_LATENCY-1, register `sin_in`/`sign_in` into `sin_value_out`/`sign_bit_out` and go to BURST.
- BURST: frame_cnt LUT_LATENCY..LUT_LATENCY+BURST_DURATION-1, with `burst_en_out`=1. On the last cycle, go to LISTEN.
- LISTEN: `listen_out`=1 until frame_cnt==PERIOD_DURATION-1. On that cycle:
  - if stop_pending, or (angle==NUM_ANGLES-1 and `continuous_in`==0): go to IDLE;
  - else angle = (angle==NUM_ANGLES-1) ? 0 : angle+1, frame_cnt=0, go to SETUP.
- `stop_in` while busy sets sticky stop_pending. A stop on the final LISTEN cycle is honoured at that boundary.
- `start_in` while busy is ignored.
- `sin_value_out`/`sign_bit_out` change only at the SETUP→BURST edge; they are held through LISTEN and into the next SETUP, and retain their value in IDLE.
- Legal configuration requires PERIOD_DURATION > LUT_LATENCY + BURST_DURATION. This is checked by an elaboration assertion.

## Timing
- Reset (rst_in low, async): state=IDLE, angle=0, frame_cnt=0, stop_pending=0. All outputs are 0, including `sin_value_out`, `sign_bit_out` and `angle_addr_out`.
- Reset mid-frame: `burst_en_out` and `listen_out` drop immediately (asynchronously). Operation resumes only on a new `start_in` after release.
- All outputs are registered. `start_in` sampled at edge N gives `busy_out`=1, `frame_start_out`=1 and `angle_addr_out`=0 from edge N onward.
- `burst_en_out` rises LUT_LATENCY cycles after `frame_start_out` and stays high for exactly BURST_DURATION cycles.
- `listen_out` follows with no gap, for PERIOD_DURATION-LUT_LATENCY-BURST_DURATION cycles.
- `burst_en_out` and `listen_out` are never high together. Frames are back-to-back with no idle cycle.
- `sweep_done_out` coincides with the last LISTEN cycle of angle NUM_ANGLES-1.
- `busy_out` falls the cycle after a terminating LISTEN cycle.

## Test plan
Params for all scenarios: PERIOD=64, BURST=16, NUM_ANGLES=4, LUT_LATENCY=2. LUT model returns sin=1000·(addr+1), sign=addr[0], with 2-cycle latency.

1. Reset values: hold rst_in low → all outputs 0. Release and idle 10 cycles → `busy_out` stays 0.
2. Single sweep (continuous=0), pulse start:
   - 4 frames of 64 cycles;
   - `burst_en_out` high cycles 2..17 of each frame;
   - `sin_value_out` = 1000, 2000, 3000, 4000 and `sign_bit_out` = 0, 1, 0, 1;
   - `sweep_done_out` at cycle 255;
   - IDLE at 256.
3. Continuous: continuous=1 → angle wraps 3→0 at cycle 256, `frame_start_out` pulses at 0, 64, …, 256, and `sweep_done_out` every 256 cycles.
4. Stop mid-frame: stop_in at cycle 70 (angle 1, BURST) → frame 1 completes, `busy_out`=0 at 128, no burst afterwards. Stop at cycle 127 → same result.
5. Ignored requests: start_in while busy → no restart, frame_cnt continues. stop_in in IDLE, then start → full sweep runs.
6. Async reset at cycle 10 (BURST) → `burst_en_out` drops the same cycle. After release + start, the sweep restarts at angle 0.
